// File: rtl/cache_instrucoes_param.sv
// Direct-mapped, read-only instruction cache with a word-serial refill engine.
// Hits answer combinationally; a miss stalls fetch while a whole block is streamed in.
module cache_instrucoes_param #(
  parameter int NUM_LINHAS     = 16,
  parameter int PALAVRAS_BLOCO = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic        pc_valido,
  input  logic        flush,
  output logic        stall_cache_instrucoes,
  output logic [31:0] instrucao_do_processador,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_data,
  output logic [31:0] contador_misses
);
  localparam int OFF  = $clog2(PALAVRAS_BLOCO * 4);
  localparam int IDX  = $clog2(NUM_LINHAS);
  localparam int TAG  = 32 - IDX - OFF;
  localparam int WSEL = OFF - 2;

  typedef logic [PALAVRAS_BLOCO-1:0][31:0] bloco_t;
  typedef enum logic {OCIOSO, RECARGA} estado_t;

  estado_t              estado;
  logic [NUM_LINHAS-1:0] valido;
  logic [TAG-1:0]       tags [NUM_LINHAS];
  bloco_t               dados [NUM_LINHAS];
  bloco_t               buffer, bloco_final;
  logic [IDX-1:0]       idx_lat;
  logic [TAG-1:0]       tag_lat;
  logic [WSEL-1:0]      contador;
  logic                 descartar;

  logic [IDX-1:0]  pc_idx;
  logic [TAG-1:0]  pc_tag;
  logic [WSEL-1:0] pc_pal;
  logic            hit, ultima;
  logic            unused_pc;

  assign pc_idx    = PC[OFF +: IDX];
  assign pc_tag    = PC[31 -: TAG];
  assign pc_pal    = PC[2 +: WSEL];
  assign unused_pc = ^PC[1:0];

  assign hit    = (estado == OCIOSO) && valido[pc_idx] && (tags[pc_idx] == pc_tag);
  assign ultima = (estado == RECARGA) && mem_valid && (contador == WSEL'(PALAVRAS_BLOCO - 1));

  assign stall_cache_instrucoes   = pc_valido && !hit;
  assign instrucao_do_processador = hit ? dados[pc_idx][pc_pal] : 32'h0;

  // The last word bypasses the buffer so the whole block installs on the same edge.
  genvar w;
  generate
    for (w = 0; w < PALAVRAS_BLOCO; w++) begin : g_bloco
      assign bloco_final[w] = (contador == WSEL'(w)) ? mem_data : buffer[w];
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado          <= OCIOSO;
      valido          <= '0;
      mem_req         <= 1'b0;
      mem_addr        <= '0;
      contador        <= '0;
      contador_misses <= '0;
      descartar       <= 1'b0;
      idx_lat         <= '0;
      tag_lat         <= '0;
    end else begin
      if (flush) valido <= '0;
      case (estado)
        OCIOSO: begin
          if (pc_valido && !hit && !flush) begin
            estado          <= RECARGA;
            idx_lat         <= pc_idx;
            tag_lat         <= pc_tag;
            mem_addr        <= {PC[31:OFF], {OFF{1'b0}}};
            mem_req         <= 1'b1;
            contador        <= '0;
            descartar       <= 1'b0;
            contador_misses <= contador_misses + 32'd1;
          end
        end
        RECARGA: begin
          // A flush anywhere in the transfer poisons the line being fetched.
          if (flush) descartar <= 1'b1;
          if (mem_valid) begin
            contador <= contador + 1'b1;
            if (ultima) begin
              if (!flush && !descartar) valido[idx_lat] <= 1'b1;
              mem_req <= 1'b0;
              estado  <= OCIOSO;
            end
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  // Tag/data storage carries no reset; the valid bits gate every read.
  always_ff @(posedge clock) begin
    if (estado == RECARGA && mem_valid) buffer[contador] <= mem_data;
    if (ultima) begin
      dados[idx_lat] <= bloco_final;
      tags[idx_lat]  <= tag_lat;
    end
  end

endmodule

// File: tb/tb_cache_instrucoes_param.sv
// Directed bench for cache_instrucoes_param: default geometry plus a 4-line/4-word instance.
module tb_cache_instrucoes_param;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] PC, mem_data;
  logic        pc_valido, flush, mem_valid;
  logic        stall, mem_req;
  logic [31:0] instr, mem_addr, misses;

  logic [31:0] pc2, md2;
  logic        pv2, fl2, mv2;
  logic        stall2, req2;
  logic [31:0] instr2, addr2, misses2;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_misses = 0;

  always #5 clock = ~clock;

  cache_instrucoes_param dut (
    .clock(clock), .reset(reset), .PC(PC), .pc_valido(pc_valido), .flush(flush),
    .stall_cache_instrucoes(stall), .instrucao_do_processador(instr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data),
    .contador_misses(misses)
  );

  cache_instrucoes_param #(.NUM_LINHAS(4), .PALAVRAS_BLOCO(4)) dut2 (
    .clock(clock), .reset(reset), .PC(pc2), .pc_valido(pv2), .flush(fl2),
    .stall_cache_instrucoes(stall2), .instrucao_do_processador(instr2),
    .mem_req(req2), .mem_addr(addr2), .mem_valid(mv2), .mem_data(md2),
    .contador_misses(misses2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Miss on pc, then stream 8 words base+i; toggle inserts a wait state every other cycle.
  task automatic refill(input logic [31:0] pc, input logic [31:0] base, input bit toggle,
                        input int flush_at);
    int i, cyc;
    logic [31:0] blk;
    blk = pc & ~32'h1F;
    PC = pc; pc_valido = 1'b1; flush = 1'b0; mem_valid = 1'b0;
    #1 chk("miss_stall", {31'b0, stall}, 32'd1);
    step();
    exp_misses++;
    i = 0; cyc = 0;
    while (i < 8 && cyc < 64) begin
      mem_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      mem_data  = mem_valid ? base + i : 32'hDEAD_BEEF;
      flush     = (cyc == flush_at);
      #1;
      chk("refill_req", {31'b0, mem_req}, 32'd1);
      chk("refill_addr", mem_addr, blk);
      chk("refill_stall", {31'b0, stall}, 32'd1);
      step();
      if (mem_valid) i++;
      cyc++;
    end
    chk("refill_words", i, 32'd8);
    mem_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; PC = 32'h40; pc_valido = 1'b1; flush = 1'b0; mem_valid = 1'b0; mem_data = '0;
    pc2 = '0; pv2 = 1'b0; fl2 = 1'b0; mv2 = 1'b0; md2 = '0;
    #2;
    chk("rst_stall", {31'b0, stall}, 32'd1);
    chk("rst_instr", instr, 32'h0);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_misses", misses, 32'h0);
    step(); step();
    reset = 1'b0;
    step();

    // 1: cold miss
    refill(32'h40, 32'h1000, 1'b0, -1);
    #1;
    chk("cold_stall", {31'b0, stall}, 32'd0);
    chk("cold_instr", instr, 32'h1000);
    chk("cold_misses", misses, 32'd1);
    chk("cold_req_off", {31'b0, mem_req}, 32'd0);

    // 2: spatial hit
    PC = 32'h4C;
    #1;
    chk("spatial_stall", {31'b0, stall}, 32'd0);
    chk("spatial_instr", instr, 32'h1003);
    step();
    chk("spatial_req", {31'b0, mem_req}, 32'd0);
    chk("spatial_misses", misses, 32'd1);

    // 3: conflict on index 2
    refill(32'h240, 32'h2000, 1'b0, -1);
    #1;
    chk("conflict_instr", instr, 32'h2000);
    chk("conflict_misses", misses, 32'd2);
    step();
    refill(32'h40, 32'h1000, 1'b0, -1);
    #1;
    chk("reload_instr", instr, 32'h1000);
    chk("reload_misses", misses, 32'd3);
    step();

    // 4: wait states
    refill(32'h80, 32'h3000, 1'b1, -1);
    for (int k = 0; k < 8; k++) begin
      PC = 32'h80 + 4 * k;
      #1 chk("waitst_word", instr, 32'h3000 + k);
      step();
    end
    chk("waitst_misses", misses, 32'd4);

    // 5: flush in idle, same-cycle lookup sees the old state
    PC = 32'h40; flush = 1'b1;
    #1;
    chk("flush_same_stall", {31'b0, stall}, 32'd0);
    chk("flush_same_instr", instr, 32'h1000);
    step();
    flush = 1'b0;
    #1 chk("flush_after_stall", {31'b0, stall}, 32'd1);
    pc_valido = 1'b0;
    step();
    PC = 32'h100; pc_valido = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; pc_valido = 1'b0;
    #1;
    chk("flush_miss_noreq", {31'b0, mem_req}, 32'd0);
    chk("flush_miss_cnt", misses, 32'd4);
    step();
    // flush during the 4th refill cycle discards the line
    refill(32'h40, 32'h4000, 1'b0, 3);
    #1;
    chk("flush_rf_stall", {31'b0, stall}, 32'd1);
    chk("flush_rf_instr", instr, 32'h0);
    refill(32'h40, 32'h1000, 1'b0, -1);
    #1;
    chk("flush_rf_refetch", instr, 32'h1000);
    chk("flush_rf_misses", misses, exp_misses);
    step();

    // 6: reset after the 3rd word
    PC = 32'h140; pc_valido = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      mem_valid = 1'b1; mem_data = 32'h7000 + k;
      step();
    end
    mem_valid = 1'b0;
    chk("pre_rst_req", {31'b0, mem_req}, 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_req", {31'b0, mem_req}, 32'd0);
    chk("midrst_misses", misses, 32'd0);
    step();
    reset = 1'b0; exp_misses = 0;
    #1;
    chk("postrst_stall", {31'b0, stall}, 32'd1);
    refill(32'h40, 32'h5000, 1'b0, -1);
    #1;
    chk("postrst_w0", instr, 32'h5000);
    chk("postrst_misses", misses, 32'd1);
    PC = 32'h44;
    #1 chk("postrst_w1", instr, 32'h5001);
    pc_valido = 1'b0;
    step();

    // 6b: 4 lines x 4 words, PC 0x30 -> index 3
    pc2 = 32'h30; pv2 = 1'b1;
    #1 chk("p4_miss_stall", {31'b0, stall2}, 32'd1);
    step();
    chk("p4_req", {31'b0, req2}, 32'd1);
    chk("p4_addr", addr2, 32'h30);
    chk("p4_misses", misses2, 32'd1);
    for (int k = 0; k < 4; k++) begin
      mv2 = 1'b1; md2 = 32'h6000 + k;
      #1 chk("p4_req_during", {31'b0, req2}, 32'd1);
      step();
    end
    mv2 = 1'b0;
    #1;
    chk("p4_req_done", {31'b0, req2}, 32'd0);
    chk("p4_hit_stall", {31'b0, stall2}, 32'd0);
    chk("p4_w0", instr2, 32'h6000);
    pc2 = 32'h3C;
    #1 chk("p4_w3", instr2, 32'h6003);
    pc2 = 32'h20;
    #1 chk("p4_idx2_miss", {31'b0, stall2}, 32'd1);
    pv2 = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
